// File: rtl/adpll_phase_det.sv
// -----------------------------------------------------------------------------
// adpll_phase_det
//   Reference-phase accumulator and phase detector for an all-digital PLL.
//   After the loop is enabled the block waits ALIGN_CYCLES enabled cycles for
//   the TDC pipeline to fill. It then seeds the reference phase from the TDC
//   word. From then on it advances the reference phase by fcw every cycle and
//   reports the wrapped difference against the TDC phase. A run of in-window
//   errors declares lock, and a single out-of-window error drops it.
//
// Ports
//   clk          rising-edge system clock (32 MHz reference)
//   rst          synchronous, active-low reset
//   en           loop enable; 0 in any active state returns the block to IDLE
//   tdc_word     [11:0] DCO phase from the TDC, LSB = 1/32 DCO period, mod 4096
//   fcw          [11:0] frequency control word, same LSB as tdc_word
//   lock_thresh  [10:0] lock window on |phase_err|
//   lock_cycles  [7:0]  consecutive in-window samples needed for lock (0 acts as 1)
//   phase_err    [11:0] signed phase error, registered
//   err_valid    phase_err holds a tracking sample
//   locked       lock indicator, registered
//   ref_phase    [11:0] reference phase accumulator, registered
//   state_dbg    [1:0]  current FSM state (0 IDLE, 1 ALIGN, 2 TRACK, 3 LOCKED)
//
// Handshake: no valid/ready flow control. A new sample is produced on every
// enabled edge in TRACK/LOCKED and is qualified by err_valid. There is no
// back-pressure.
// -----------------------------------------------------------------------------
module adpll_phase_det #(
  parameter int ALIGN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] tdc_word,
  input  logic [11:0] fcw,
  input  logic [10:0] lock_thresh,
  input  logic [7:0]  lock_cycles,
  output logic [11:0] phase_err,
  output logic        err_valid,
  output logic        locked,
  output logic [11:0] ref_phase,
  output logic [1:0]  state_dbg
);

  localparam int AW = (ALIGN_CYCLES > 1) ? $clog2(ALIGN_CYCLES) : 1;
  localparam logic [AW-1:0] ALIGN_LAST = AW'(ALIGN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIGN  = 2'd1,
    TRACK  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] align_cnt, align_cnt_n;
  logic [7:0]    lock_cnt, lock_cnt_n;
  logic [11:0]   phase_err_n, ref_phase_n;
  logic          err_valid_n, locked_n;

  // Tracking datapath. All phase arithmetic wraps mod 4096, so accumulator
  // or TDC roll-over produces no error discontinuity.
  logic [11:0] ref_adv;
  logic [11:0] err_new;
  logic [11:0] err_mag;
  logic        in_win;
  logic [7:0]  cnt_inc;
  logic [7:0]  lock_target;

  assign ref_adv     = ref_phase + fcw;
  assign err_new     = ref_adv - tdc_word;
  // 12-bit magnitude: -2048 maps to 2048 (0x800). 2048 exceeds any 11-bit
  // threshold, so that sample is never in-window.
  assign err_mag     = err_new[11] ? (~err_new + 12'd1) : err_new;
  assign in_win      = (err_mag <= {1'b0, lock_thresh});
  assign cnt_inc     = (lock_cnt == 8'hFF) ? 8'hFF : lock_cnt + 8'd1;
  assign lock_target = (lock_cycles == 8'd0) ? 8'd1 : lock_cycles;

  assign state_dbg = state;

  always_comb begin
    state_n     = state;
    align_cnt_n = align_cnt;
    lock_cnt_n  = lock_cnt;
    phase_err_n = phase_err;
    ref_phase_n = ref_phase;
    err_valid_n = err_valid;
    locked_n    = locked;

    if (state != IDLE && !en) begin
      // Loop disabled: drop back to IDLE, keep ref_phase where it was.
      state_n     = IDLE;
      align_cnt_n = '0;
      lock_cnt_n  = 8'd0;
      phase_err_n = 12'd0;
      err_valid_n = 1'b0;
      locked_n    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          phase_err_n = 12'd0;
          err_valid_n = 1'b0;
          locked_n    = 1'b0;
          if (en) begin
            state_n     = ALIGN;
            align_cnt_n = '0;
          end
        end
        ALIGN: begin
          if (align_cnt == ALIGN_LAST) begin
            ref_phase_n = tdc_word;
            state_n     = TRACK;
          end else begin
            align_cnt_n = align_cnt + 1'b1;
          end
        end
        TRACK, LOCKED: begin
          ref_phase_n = ref_adv;
          phase_err_n = err_new;
          err_valid_n = 1'b1;
          lock_cnt_n  = in_win ? cnt_inc : 8'd0;
          if (state == TRACK) begin
            // >= rather than == so a lowered lock_cycles still locks.
            if (in_win && cnt_inc >= lock_target) begin
              state_n  = LOCKED;
              locked_n = 1'b1;
            end
          end else if (!in_win) begin
            state_n  = TRACK;
            locked_n = 1'b0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      align_cnt <= '0;
      lock_cnt  <= 8'd0;
      phase_err <= 12'd0;
      ref_phase <= 12'd0;
      err_valid <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_n;
      align_cnt <= align_cnt_n;
      lock_cnt  <= lock_cnt_n;
      phase_err <= phase_err_n;
      ref_phase <= ref_phase_n;
      err_valid <= err_valid_n;
      locked    <= locked_n;
    end
  end

endmodule

// File: tb/tb_adpll_phase_det.sv
// -----------------------------------------------------------------------------
// tb_adpll_phase_det
//   Self-checking bench for adpll_phase_det. The driver applies stimulus on the
//   falling edge and pushes the expected post-edge outputs from a behavioural
//   model. A monitor pops and compares just after each rising edge.
// -----------------------------------------------------------------------------
module tb_adpll_phase_det;

  localparam int AC = 2;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [11:0] tdc_word = '0;
  logic [11:0] fcw = '0;
  logic [10:0] lock_thresh = '0;
  logic [7:0]  lock_cycles = '0;
  logic [11:0] phase_err;
  logic        err_valid;
  logic        locked;
  logic [11:0] ref_phase;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  adpll_phase_det #(.ALIGN_CYCLES(AC)) dut (
    .clk(clk), .rst(rst), .en(en), .tdc_word(tdc_word), .fcw(fcw),
    .lock_thresh(lock_thresh), .lock_cycles(lock_cycles),
    .phase_err(phase_err), .err_valid(err_valid), .locked(locked),
    .ref_phase(ref_phase), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  // packed as {state[1:0], ref[11:0], valid, locked, err[11:0]}
  logic [27:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
  endtask

  always @(posedge clk) begin
    logic [27:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("state",     int'(state_dbg), int'(e[27:26]));
      check("ref_phase", int'(ref_phase), int'(e[25:14]));
      check("err_valid", int'(err_valid), int'(e[13]));
      check("locked",    int'(locked),    int'(e[12]));
      check("phase_err", int'(phase_err), int'(e[11:0]));
    end
  end

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 aligning, 2 tracking, 3 locked
  int m_mode = 0, m_ref = 0, m_err = 0, m_valid = 0, m_locked = 0;
  int m_run = 0, m_wait = 0;

  function automatic int wrap(input int x);
    return ((x % 4096) + 4096) % 4096;
  endfunction

  task automatic model_edge(input bit r, input bit e, input int tdc,
                            input int f, input int thr, input int lc);
    int d, er, mag, need;
    bit inwin;
    if (!r) begin
      m_mode = 0; m_ref = 0; m_err = 0; m_valid = 0; m_locked = 0;
      m_run = 0; m_wait = 0;
    end else if (m_mode != 0 && !e) begin
      m_mode = 0; m_err = 0; m_valid = 0; m_locked = 0; m_run = 0; m_wait = 0;
    end else if (m_mode == 0) begin
      if (e) begin m_mode = 1; m_wait = 0; end
    end else if (m_mode == 1) begin
      if (m_wait == AC - 1) begin m_ref = tdc; m_mode = 2; end
      else m_wait++;
    end else begin
      m_ref = wrap(m_ref + f);
      d = wrap(m_ref - tdc);
      er = (d >= 2048) ? d - 4096 : d;
      mag = (er < 0) ? -er : er;
      inwin = (mag <= thr);
      m_err = er;
      m_valid = 1;
      m_run = inwin ? ((m_run < 255) ? m_run + 1 : 255) : 0;
      need = (lc == 0) ? 1 : lc;
      if (m_mode == 2 && inwin && m_run >= need) begin m_mode = 3; m_locked = 1; end
      else if (m_mode == 3 && !inwin) begin m_mode = 2; m_locked = 0; end
    end
  endtask

  // ---------------- driver ----------------
  int g_fcw = 2500, g_thr = 4, g_lc = 8, cur_tdc = 0;

  task automatic drive(input bit r, input bit e, input int tdc);
    logic [27:0] x;
    @(negedge clk);
    rst = r; en = e; tdc_word = tdc[11:0]; fcw = g_fcw[11:0];
    lock_thresh = g_thr[10:0]; lock_cycles = g_lc[7:0];
    model_edge(r, e, tdc, g_fcw, g_thr, g_lc);
    x[27:26] = m_mode[1:0];
    x[25:14] = m_ref[11:0];
    x[13]    = m_valid[0];
    x[12]    = m_locked[0];
    x[11:0]  = wrap(m_err) & 12'hFFF;
    exp_q.push_back(x);
  endtask

  task automatic run(input int n, input int step, input bit e);
    for (int i = 0; i < n; i++) begin
      cur_tdc = wrap(cur_tdc + step);
      drive(1'b1, e, cur_tdc);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int off;
    // reset
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 0);

    // locked tracking, then frequency offset from locked
    g_fcw = 2500; g_thr = 4; g_lc = 8; cur_tdc = 123;
    run(20, 2500, 1'b1);
    run(8, 2501, 1'b1);

    // enable drop while locked (re-align, re-lock first)
    run(2, 2500, 1'b0);
    run(16, 2500, 1'b1);
    run(1, 2500, 1'b0);
    run(3, 2500, 1'b0);

    // reset mid-lock
    run(16, 2500, 1'b1);
    cur_tdc = wrap(cur_tdc + 2500);
    drive(1'b0, 1'b1, cur_tdc);
    run(16, 2500, 1'b1);

    // wrap: third enabled edge sees tdc_word = 4000
    run(2, 2500, 1'b0);
    cur_tdc = wrap(4000 - 3 * 2500);
    run(15, 2500, 1'b1);

    // extreme error of exactly -2048
    g_thr = 2047; g_lc = 1;
    run(4, 2500, 1'b1);
    run(1, 2500 + 2048, 1'b1);
    run(3, 2500, 1'b1);

    // randomized segment
    for (int i = 0; i < 400; i++) begin
      if (i % 40 == 0) begin
        g_thr = $urandom_range(0, 8);
        g_lc  = $urandom_range(0, 6);
        if ($urandom_range(0, 1) == 1) g_fcw = $urandom_range(0, 4095);
      end
      off = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(0, 6)) - 3;
      if ($urandom_range(0, 99) < 2) off = int'($urandom_range(0, 4095));
      cur_tdc = wrap(cur_tdc + g_fcw + off);
      drive(($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1,
            ($urandom_range(0, 99) < 5) ? 1'b0 : 1'b1, cur_tdc);
    end

    run(2, g_fcw, 1'b0);
    @(posedge clk);
    #3;
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
